// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte-serial adder: FSM states, byte width
// and the beat-counter width helper.
package byte_serial_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_e;

    // The counter must be able to hold the value MAX_BYTES itself.
    function automatic int unsigned cnt_width(input int unsigned max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/byte_serial_adder_adder.sv
// 8-bit add-with-carry block: {cout, sum} = a + b + cin.
module byte_serial_adder_adder
    import byte_serial_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cin_i,
    output logic [BYTE_W-1:0] sum_o,
    output logic              cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, cin_i};

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-byte adder, LSB first, with a single registered output stage
// and truncation of words that run past MAX_BYTES beats.
module byte_serial_adder
    import byte_serial_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_x,
    input  logic [BYTE_W-1:0] in_y,
    input  logic              in_cin,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_overlen
);

    localparam int unsigned CntW = cnt_width(MAX_BYTES);

    state_e            state_q, state_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              last_q, last_d;
    logic              cout_q, cout_d;
    logic              ovl_q, ovl_d;

    logic              in_fire;
    logic              out_fire;
    logic              cin_eff;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic [CntW-1:0]   beat_num;
    logic              force_last;
    logic              is_last;

    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    assign cin_eff    = (state_q == FIRST) ? in_cin : carry_q;
    assign beat_num   = (state_q == FIRST) ? CntW'(1) : cnt_q + CntW'(1);
    assign force_last = !in_last && (beat_num == CntW'(MAX_BYTES));
    assign is_last    = in_last || force_last;

    byte_serial_adder_adder u_adder (
        .a_i   (in_x),
        .b_i   (in_y),
        .cin_i (cin_eff),
        .sum_o (add_sum),
        .cout_o(add_cout)
    );

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovl_d   = ovl_q;
        if (in_fire) begin
            state_d = is_last ? FIRST : MID;
            carry_d = add_cout;
            cnt_d   = beat_num;
            valid_d = 1'b1;
            sum_d   = add_sum;
            last_d  = is_last;
            cout_d  = is_last ? add_cout : 1'b0;
            ovl_d   = force_last;
        end else if (out_fire) begin
            // Idle output register reads as all zeros.
            valid_d = 1'b0;
            sum_d   = '0;
            last_d  = 1'b0;
            cout_d  = 1'b0;
            ovl_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FIRST;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovl_q   <= ovl_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_sum     = sum_q;
    assign out_last    = last_q;
    assign out_carry   = cout_q;
    assign out_overlen = ovl_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: directed beats push expected bytes,
// a negedge monitor pops and compares each presented output byte.
module tb_byte_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic       in_cin;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_carry;
    logic       out_overlen;

    byte_serial_adder #(.MAX_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_cin     (in_cin),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_last   (out_last),
        .out_carry  (out_carry),
        .out_overlen(out_overlen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       l;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   head_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: out_ready only changes just after a rising edge, so valid&&ready
    // at the falling edge means the byte transfers on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got sum %h last %b, expected none",
                         out_sum, out_last);
            end else begin
                if (!head_seen) begin
                    chk("latency", cyc, q[0].acc);
                    head_seen = 1;
                end
                chk("out_byte", {out_sum, out_last, out_carry, out_overlen},
                    {q[0].s, q[0].l, q[0].c, q[0].o});
                if (out_ready) begin
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic cin,
                        input logic last, input logic [7:0] es, input logic el,
                        input logic ec, input logic eo);
        exp_t e;
        logic rdy;
        bit   done;
        done     = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_cin   = cin;
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                e.s = es; e.l = el; e.c = ec; e.o = eo; e.acc = cyc;
                q.push_back(e);
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no in_ready, expected acceptance of %h+%h", x, y);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {out_sum, out_last, out_carry, out_overlen}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);

        // Carry rippling into the second byte.
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        // Word carry-out.
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        // Single-beat words; carry must not leak between words.
        send(8'h7F, 8'h80, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        send(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("idle_zero_outputs", {out_valid, out_sum, out_last, out_carry, out_overlen}, 0);

        // Backpressure: hold A, present B, then release.
        out_ready = 1'b0;
        send(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        in_x = 8'h11; in_y = 8'h22; in_cin = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold", {out_valid, out_sum, out_last}, {1'b1, 8'h30, 1'b1});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h11, 8'h22, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("no_bubble_valid", out_valid, 1);
        idle(2);

        // Truncation at MAX_BYTES=4; beat 5 starts a new word.
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        // Same truncation, but the new word's first beat samples cin=0.
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a word with carry pending.
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("midword_rst_valid", out_valid, 0);
        chk("midword_rst_in_ready", in_ready, 1);
        q.delete();
        head_seen = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 Parameter MAX_BYTES, default 4, SHALL set the maximum number of byte beats per operand word (range 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 in_valid  input  1  SHALL mean the upstream byte pair is valid.
REQ-005 in_ready  output  1  SHALL mean the block accepts the pair this cycle.
REQ-006 in_x  input  8  SHALL be the operand X byte, least-significant byte first.
REQ-007 in_y  input  8  SHALL be the operand Y byte, least-significant byte first.
REQ-008 in_cin  input  1  SHALL be the word carry-in, sampled only on the first beat of a word.
REQ-009 in_last  input  1  SHALL mark the final byte of the word.
REQ-010 out_valid  output  1  SHALL mean the output byte is valid.
REQ-011 out_ready  input  1  SHALL mean downstream accepts the output byte.
REQ-012 out_sum  output  8  SHALL be the sum byte.
REQ-013 out_last  output  1  SHALL mark the final sum byte of the word.
REQ-014 out_carry  output  1  SHALL be the word carry-out; valid only with out_last=1, otherwise 0.
REQ-015 out_overlen  output  1  SHALL flag, with out_last=1, a word truncated at MAX_BYTES beats.

Function
REQ-016 Transfer SHALL occur when valid and ready are both 1 on the same edge, on each side independently.
REQ-017 FSM SHALL have states FIRST (next beat starts a word) and MID (inside a word).
REQ-018 Each accepted beat SHALL compute {c,s} = in_x + in_y + cin_eff as a 9-bit sum, with cin_eff = in_cin in FIRST and the carry register in MID.
REQ-019 Accepted beat SHALL load s into out_sum and set out_valid=1 on the next edge: latency exactly 1 cycle.
REQ-020 Carry register SHALL load c on every accepted beat.
REQ-021 Beat counter SHALL reset to 1 on a FIRST beat and increment on each MID beat.
REQ-022 Beat with in_last=1 SHALL set out_last=1, out_carry=c, and return the FSM to FIRST.
REQ-023 Beat with in_last=0 in FIRST or MID SHALL move/stay in MID with out_last=0, out_carry=0.
REQ-024 Beat number MAX_BYTES with in_last=0 SHALL be forced last: out_last=1, out_carry=c, out_overlen=1, FSM to FIRST; the next beat starts a new word and samples in_cin.
REQ-025 in_ready SHALL equal !out_valid || out_ready (single output register, full-throughput pass-through, combinational ready path allowed).
REQ-026 With out_valid=1 and out_ready=0, all outputs SHALL hold stable and no input SHALL be accepted.
REQ-027 Simultaneous output accept and input accept SHALL replace the output register with the new beat; out_valid stays 1.
REQ-028 Output accept without input accept SHALL clear out_valid on the next edge.
REQ-029 out_sum, out_last, out_carry, out_overlen SHALL be 0 whenever out_valid=0.

Reset
REQ-030 rst=1 SHALL asynchronously force: FSM=FIRST, carry register=0, beat counter=0, out_valid=0, out_sum=0, out_last=0, out_carry=0, out_overlen=0.
REQ-031 Reset mid-word SHALL discard the partial word and any held output; the first beat after deassertion starts a new word.
REQ-032 in_ready SHALL be 1 during and immediately after reset, since out_valid=0.

Structure
REQ-033 Shared package byte_serial_pkg SHALL hold the FSM state enum (FIRST, MID), the byte width constant 8, and the beat-counter width function of MAX_BYTES.
REQ-034 Per-beat arithmetic SHALL instantiate the existing 8-bit add-with-carry block adder as a sub-module; the block SHALL contain no other adder.

Verification
REQ-035 Scenario: cin=0, beats (FF,01,last=0),(00,00,last=1), out_ready=1 -> out_sum 00 then 01, out_carry=0 on last, each one cycle after acceptance.
REQ-036 Scenario: cin=0, beats (FF,01,0),(FF,00,1) -> out_sum 00,00; out_last=1, out_carry=1 on the second byte.
REQ-037 Scenario: cin=1, single beat (7F,80,last=1) -> out_sum 00, out_carry=1, out_last=1; then beat (01,01,1) with cin=0 -> out_sum 02, out_carry=0 (the carry does not leak across words).
REQ-038 Scenario: out_ready=0 for 3 cycles with one output held -> in_ready=0, outputs stable; release with in_valid=1 -> back-to-back transfer with no bubble.
REQ-039 Scenario: MAX_BYTES=4, five beats all in_last=0 with x=FF, y=00, cin=1 -> beat 4 out_last=1, out_overlen=1, out_carry=1; beat 5 treated as new word using in_cin.
REQ-040 Scenario: rst pulsed after beat 2 of a 4-byte word -> out_valid=0 immediately; the next word's first beat uses in_cin, not the stale carry.
